// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Holds default operand widths, the step-counter width and the FSM state enum.
// Imported by div_step and seq_restoring_divider.
package div_pkg;

  // Default dividend/quotient and divisor/remainder widths.
  localparam int NW_DEF = 8;
  localparam int DW_DEF = 4;

  // The step counter must hold values 0..NW.
  localparam int CNT_W = $clog2(NW_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports:
//   pr      - current partial remainder (DW bits)
//   n_msb   - next dividend bit, shifted in at the LSB of the trial value
//   d       - divisor (DW bits)
//   pr_next - partial remainder after this step
//   q_bit   - quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] pr,
  input  logic          n_msb,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] pr_next,
  output logic          q_bit
);

  logic [DW:0] trial;
  logic [DW:0] d_ext;
  logic [DW:0] diff;

  assign trial = {pr, n_msb};
  assign d_ext = {1'b0, d};
  assign diff  = trial - d_ext;

  // pr < d holds on entry, so a successful subtraction always fits in DW bits.
  // With d == 0 the subtraction always "succeeds" and the remainder is the
  // dividend's low bits shifted through, giving q = all ones.
  always_comb begin
    q_bit   = 1'b0;
    pr_next = trial[DW-1:0];
    if (trial >= d_ext) begin
      q_bit   = 1'b1;
      pr_next = diff[DW-1:0];
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: NW+1 cycles from accepting start to the done pulse (1 with a
//   detected zero divisor when DIV_ZERO_DETECT_EN is defined).
// Backpressure: start is accepted only in IDLE or DONE; it is ignored in RUN.
// Optional feature macro: DIV_ZERO_DETECT_EN (adds dz port and early exit).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - request a division (sampled in IDLE/DONE)
//   dividend, divisor - operands, sampled on the accepting edge
//   busy              - iterations in progress
//   done              - one-cycle pulse when quotient/remainder are updated
//   quotient, remainder - result, held until the next completion
//   dz                - divide-by-zero flag (DIV_ZERO_DETECT_EN only)
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF   // must be smaller than NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
`ifdef DIV_ZERO_DETECT_EN
  output logic [DW-1:0] remainder,
  output logic          dz
`else
  output logic [DW-1:0] remainder
`endif
);

  localparam int            CW   = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  div_state_t    state;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB,
  // so after NW steps this register holds the quotient.
  logic [NW-1:0] nq;
  logic [DW-1:0] d_reg;
  logic [DW-1:0] pr;
  logic [CW-1:0] cnt;

  logic [DW-1:0] pr_next;
  logic          q_bit;

  div_step #(.DW(DW)) u_step (
    .pr      (pr),
    .n_msb   (nq[NW-1]),
    .d       (d_reg),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      nq        <= '0;
      d_reg     <= '0;
      pr        <= '0;
      cnt       <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            nq    <= dividend;
            d_reg <= divisor;
            pr    <= '0;
            cnt   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == '0) begin
              // Skip the iterations; the result is the same one the
              // unmodified algorithm would produce.
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[DW-1:0];
              dz        <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dz    <= 1'b0;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          nq  <= {nq[NW-2:0], q_bit};
          pr  <= pr_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {nq[NW-2:0], q_bit};
            remainder <= pr_next;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours DIV_ZERO_DETECT_EN for the dz port and zero-divisor timing.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic       dz;
`endif

  int vectors;
  int miscompares;

  seq_restoring_divider #(.NW(8), .DW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV_ZERO_DETECT_EN
    .remainder (remainder),
    .dz        (dz)
`else
    .remainder (remainder)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add model of the 4-bit array multiplier, widened for an 8-bit q.
  function automatic logic [11:0] arr_mul(input logic [7:0] a, input logic [3:0] b);
    logic [11:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) acc = acc + ({4'b0, a} << i);
    return acc;
  endfunction

  // Issue one start and observe until done. k counts falling edges after the
  // accepting edge E (k=0 is the cycle after E); done_k = -1 on timeout.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                        output int done_k, output int busy_cnt,
                        output bit both_hi, output logic [7:0] q_first);
    done_k   = -1;
    busy_cnt = 0;
    both_hi  = 1'b0;
    q_first  = '0;
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 4'h0;
        q_first  = quotient;
      end
      if (busy) busy_cnt++;
      if (busy && done) both_hi = 1'b1;
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d, want all 0",
               busy, done, quotient, remainder);
    end
`ifdef DIV_ZERO_DETECT_EN
    vectors++;
    if (dz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dz: got %b want 0", dz);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dk, bc;
    bit bh;
    logic [7:0] qf;
    run_op(8'd200, 4'd7, dk, bc, bh, qf);
    vectors++;
    if (dk !== 8 || bc !== 8 || bh !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_timing: done_k=%0d busy_cycles=%0d overlap=%b, want 8 8 0", dk, bc, bh);
    end
    vectors++;
    if (quotient !== 8'd28 || remainder !== 4'd4) begin
      miscompares++;
      $display("FAIL basic_result: q=%0d r=%0d, want q=28 r=4", quotient, remainder);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done=%b busy=%b q=%0d, want 0 0 28", done, busy, quotient);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    seen = 0;
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);   // now in the 4th busy cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, done, quotient, remainder} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d, want all 0",
               busy, done, quotient, remainder);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: %0d cycles with busy/done after abort, want 0", seen);
    end
  endtask

  task automatic test_edges();
    logic [7:0] n_t [3] = '{8'd255, 8'd5, 8'd0};
    logic [3:0] d_t [3] = '{4'd15, 4'd9, 4'd1};
    logic [7:0] q_t [3] = '{8'd17, 8'd0, 8'd0};
    logic [3:0] r_t [3] = '{4'd0, 4'd5, 4'd0};
    int dk, bc;
    bit bh;
    logic [7:0] qf, q_prev;
    q_prev = quotient;
    for (int i = 0; i < 3; i++) begin
      run_op(n_t[i], d_t[i], dk, bc, bh, qf);
      vectors++;
      if (dk !== 8 || bc !== 8 || bh !== 1'b0 || qf !== q_prev ||
          quotient !== q_t[i] || remainder !== r_t[i]) begin
        miscompares++;
        $display("FAIL edge_%0d: n=%0d d=%0d done_k=%0d busy=%0d held_q=%0d q=%0d r=%0d, want 8 8 %0d %0d %0d",
                 i, n_t[i], d_t[i], dk, bc, qf, quotient, remainder, q_prev, q_t[i], r_t[i]);
      end
      q_prev = q_t[i];
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int dk, bc;
    bit bh;
    logic [7:0] qf;
    int dk2;
    run_op(8'd200, 4'd7, dk, bc, bh, qf);
    // Now in the DONE cycle: issue the second request here.
    vectors++;
    if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 4'd4) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b q=%0d r=%0d, want 1 28 4", done, quotient, remainder);
    end
    dividend = 8'd99;
    divisor  = 4'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    dk2 = -1;
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      if (k == 3) begin
        dividend = 8'd1;
        divisor  = 4'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dk2 = k;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (dk2 !== 8 || quotient !== 8'd9 || remainder !== 4'd9) begin
      miscompares++;
      $display("FAIL b2b_second: done_k=%0d q=%0d r=%0d, want 8 9 9", dk2, quotient, remainder);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_restart: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_div_zero();
    int dk, bc;
    bit bh;
    logic [7:0] qf;
    run_op(8'hA6, 4'd0, dk, bc, bh, qf);
`ifdef DIV_ZERO_DETECT_EN
    vectors++;
    if (dk !== 0 || bc !== 0 || dz !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_timing: done_k=%0d busy=%0d dz=%b, want 0 0 1", dk, bc, dz);
    end
`else
    vectors++;
    if (dk !== 8 || bc !== 8 || bh !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_timing: done_k=%0d busy=%0d overlap=%b, want 8 8 0", dk, bc, bh);
    end
`endif
    vectors++;
    if (quotient !== 8'hFF || remainder !== 4'd6) begin
      miscompares++;
      $display("FAIL dz_result: q=%h r=%0d, want ff 6", quotient, remainder);
    end
    @(negedge clk);
`ifdef DIV_ZERO_DETECT_EN
    vectors++;
    if (dz !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_hold: dz=%b want 1", dz);
    end
    run_op(8'd200, 4'd7, dk, bc, bh, qf);
    vectors++;
    if (dz !== 1'b0 || quotient !== 8'd28) begin
      miscompares++;
      $display("FAIL dz_clear: dz=%b q=%0d, want 0 28", dz, quotient);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_exhaustive();
    int dk, bc;
    bit bh;
    logic [7:0] qf;
    logic [11:0] prod;
    int shown;
    shown = 0;
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        run_op(8'(n), 4'(d), dk, bc, bh, qf);
        prod = arr_mul(quotient, 4'(d));
        vectors++;
        if (dk !== 8 || (prod + {8'b0, remainder}) !== 12'(n) ||
            {28'b0, remainder} >= d || {24'b0, quotient} !== (n / d)) begin
          miscompares++;
          if (shown < 10)
            $display("FAIL roundtrip: n=%0d d=%0d done_k=%0d q=%0d r=%0d, want q=%0d r=%0d",
                     n, d, dk, quotient, remainder, n / d, n % d);
          shown++;
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_edges();
    test_back_to_back();
    test_div_zero();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
